// File: rtl/dot_product_sequencer_if.sv
// rtl/dot_product_sequencer_if.sv - operand, multiplier and result signals of the dot product sequencer
interface dot_product_sequencer_if #(
    parameter int ACC_W = 24
);
    logic                    start;
    logic signed [15:0]      bias;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [7:0]       in_a;
    logic signed [7:0]       in_b;
    logic signed [7:0]       mul_dataa;
    logic signed [7:0]       mul_datab;
    logic signed [7:0]       mul_sumin;
    logic                    mul_clken;
    logic signed [15:0]      mul_result;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;

    modport master (
        output start, bias, in_valid, in_a, in_b, mul_result, out_ready,
        input  in_ready, mul_dataa, mul_datab, mul_sumin, mul_clken, out_valid, out_data, busy
    );

    modport slave (
        input  start, bias, in_valid, in_a, in_b, mul_result, out_ready,
        output in_ready, mul_dataa, mul_datab, mul_sumin, mul_clken, out_valid, out_data, busy
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - feeds VEC_LEN operand pairs to dsp_multiplier and accumulates bias + products
// Optional build macro DOT_PRODUCT_SEQUENCER_RELU_EN clamps negative results to zero.
module dot_product_sequencer #(
    parameter int VEC_LEN = 9,
    parameter int MUL_LAT = 1,
    parameter int ACC_W   = 24
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    dot_product_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        count;
    logic [MUL_LAT:0]        tag;
    logic signed [ACC_W-1:0] acc, acc_sum, res, out_q;
    logic signed [7:0]       dataa_q, datab_q;
    logic                    hs, last_pair, acc_en, drained, clken;

    assign clken     = (state == FEED) || (state == DRAIN);
    assign hs        = bus.in_valid && (state == FEED);
    assign last_pair = (count == CNT_W'(VEC_LEN - 1));
    assign acc_en    = clken && tag[MUL_LAT];
    // Nothing is left in flight once only the last stage is occupied.
    assign drained   = (tag[MUL_LAT-1:0] == '0);

    always_comb begin
        acc_sum = acc;
        if (acc_en)
            acc_sum = acc + {{(ACC_W-16){bus.mul_result[15]}}, bus.mul_result};
    end

`ifdef DOT_PRODUCT_SEQUENCER_RELU_EN
    assign res = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
    assign res = acc_sum;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)        state_nxt = FEED;
            FEED:    if (hs && last_pair)  state_nxt = DRAIN;
            DRAIN:   if (drained)          state_nxt = OUT;
            OUT:     if (bus.out_ready)    state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state   <= IDLE;
            count   <= '0;
            tag     <= '0;
            acc     <= '0;
            out_q   <= '0;
            dataa_q <= '0;
            datab_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                acc   <= {{(ACC_W-16){bus.bias[15]}}, bus.bias};
                count <= '0;
            end else begin
                acc <= acc_sum;
            end
            if (hs) begin
                dataa_q <= bus.in_a;
                datab_q <= bus.in_b;
                count   <= count + CNT_W'(1);
            end
            // A zero tag enters on bubbles so the tag stays aligned with the multiplier pipeline.
            if (clken)
                tag <= {tag[MUL_LAT-1:0], hs};
            if (state == DRAIN && drained)
                out_q <= res;
        end
    end

    assign bus.in_ready  = (state == FEED);
    assign bus.mul_clken = clken;
    assign bus.mul_dataa = dataa_q;
    assign bus.mul_datab = datab_q;
    assign bus.mul_sumin = 8'sd0;
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - scoreboard bench for dot_product_sequencer with a dsp_multiplier model
module tb_dot_product_sequencer;
    localparam int VEC_LEN = 9;
    localparam int MUL_LAT = 1;
    localparam int ACC_W   = 24;

    logic clock  = 1'b0;
    logic aclr_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [ACC_W-1:0]  sb[$];
    logic signed [7:0] va[VEC_LEN];
    logic signed [7:0] vb[VEC_LEN];
    logic signed [15:0] mpipe[MUL_LAT];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dot_product_sequencer_if #(.ACC_W(ACC_W)) bus ();

    dot_product_sequencer #(.VEC_LEN(VEC_LEN), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    // Pipelined signed multiplier with clock enable
    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
        end else if (bus.mul_clken) begin
            mpipe[0] <= bus.mul_dataa * bus.mul_datab + 16'(bus.mul_sumin);
            for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign bus.mul_result = mpipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_dot(input logic signed [15:0] b_v, input int bub_at, input int bub_len,
                           input int hold, input bit pulse_start);
        longint           s;
        logic [ACC_W-1:0] e, exp_res;
        int               t0, n;
        s = b_v;
        for (int i = 0; i < VEC_LEN; i++) s += va[i] * vb[i];
        e = s[ACC_W-1:0];
`ifdef DOT_PRODUCT_SEQUENCER_RELU_EN
        if (e[ACC_W-1]) e = '0;
`endif
        @(negedge clock);
        bus.start = 1'b1;
        bus.bias  = b_v;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        t0 = cyc;
        check("busy_after_start", bus.busy, 1);
        check("in_ready_feed", bus.in_ready, 1);
        for (int i = 0; i < VEC_LEN; i++) begin
            if (i == bub_at) begin
                for (int k = 0; k < bub_len; k++) begin
                    bus.in_valid = 1'b0;
                    bus.in_a     = 8'($urandom);
                    bus.in_b     = 8'($urandom);
                    @(posedge clock);
                    @(negedge clock);
                    if (i > 0) check("bubble_hold", bus.mul_dataa, va[i-1]);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_a     = va[i];
            bus.in_b     = vb[i];
            if (pulse_start && i == 2) bus.start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            bus.start = 1'b0;
            check("operand_a", bus.mul_dataa, va[i]);
            check("operand_b", bus.mul_datab, vb[i]);
        end
        // Junk with in_valid high after the last pair must not be consumed.
        bus.in_a = 8'sh55;
        bus.in_b = 8'sh7f;
        check("in_ready_drain", bus.in_ready, 0);
        check("clken_drain", bus.mul_clken, 1);
        bus.out_ready = (hold == 0);
        n = 0;
        while (!bus.out_valid && n < 64) begin
            check("busy_wait", bus.busy, 1);
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        check("latency", cyc - t0, VEC_LEN + MUL_LAT + 1 + bub_len);
        check("sb_depth", sb.size(), 1);
        exp_res = (sb.size() != 0) ? sb.pop_front() : 'x;
        for (int k = 0; k < hold; k++) begin
            check("hold_data", $unsigned(bus.out_data), exp_res);
            check("hold_valid", bus.out_valid, 1);
            check("hold_busy", bus.busy, 1);
            @(posedge clock);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        check("result", $unsigned(bus.out_data), exp_res);
        check("clken_out", bus.mul_clken, 0);
        @(posedge clock);
        @(negedge clock);
        check("out_valid_drop", bus.out_valid, 0);
        check("busy_idle", bus.busy, 0);
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < VEC_LEN; i++) begin
            va[i] = 8'(a);
            vb[i] = 8'(b);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_mul_clken"}, bus.mul_clken, 0);
        check({tag, "_out_data"}, $unsigned(bus.out_data), 0);
        check({tag, "_mul_dataa"}, bus.mul_dataa, 0);
        check({tag, "_mul_datab"}, bus.mul_datab, 0);
        check({tag, "_mul_sumin"}, bus.mul_sumin, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        aclr_n = 1'b1;
        @(negedge clock);
        check_reset_values("post_reset");

        fill(1, 2);
        run_dot(16'sd3, -1, 0, 0, 1'b0);
        fill(-128, -128);
        run_dot(16'sd0, -1, 0, 0, 1'b0);
        fill(-128, 127);
        run_dot(16'sd0, -1, 0, 0, 1'b0);
        for (int i = 0; i < VEC_LEN; i++) begin
            va[i] = 8'(i * 3 - 7);
            vb[i] = 8'(11 - i * 5);
        end
        run_dot(-16'sd100, 4, 2, 0, 1'b0);
        run_dot(16'sd1234, -1, 0, 5, 1'b1);

        // Abort mid-FEED after five pairs
        fill(50, 50);
        @(negedge clock);
        bus.start = 1'b1;
        bus.bias  = 16'sd77;
        @(posedge clock);
        @(negedge clock);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_a = va[i];
            bus.in_b = vb[i];
            @(posedge clock);
            @(negedge clock);
        end
        aclr_n = 1'b0;
        #1;
        check_reset_values("abort");
        bus.in_valid = 1'b0;
        @(negedge clock);
        aclr_n = 1'b1;
        fill(1, 1);
        run_dot(16'sd0, -1, 0, 0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            run_dot(16'($urandom), int'($urandom_range(1, VEC_LEN - 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
